// File: rtl/rob_commit.sv
// rob_commit: circular reorder buffer with in-order retirement and mispredict flush.
// Define ROB_PERF_CNT_EN to add saturating commit/mispredict performance counters.
module rob_commit #(
    parameter int ROB_ENTRY    = 16,
    parameter int NUM_ARCH_REG = 8,
    parameter int NUM_PHYS_REG = 32,
    parameter int WORD_SIZE_P  = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            rename_rob_v_i,
    input  logic [WORD_SIZE_P-1:0]          rename_pc_i,
    input  logic                            rename_is_spec_i,
    input  logic                            rename_is_store_i,
    input  logic                            rename_w_v_i,
    input  logic [$clog2(NUM_ARCH_REG)-1:0] rename_alloc_reg_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] rename_freed_reg_i,
    output logic                            rob_ready_o,
    output logic [$clog2(ROB_ENTRY)-1:0]    rob_num_o,
    input  logic                            wb_v_i,
    input  logic [$clog2(ROB_ENTRY)-1:0]    wb_rob_i,
    input  logic                            wb_mispredict_i,
    input  logic [WORD_SIZE_P-1:0]          wb_resolved_pc_i,
    output logic                            commit_v_o,
    output logic                            commit_w_v_o,
    output logic [$clog2(NUM_ARCH_REG)-1:0] commit_alloc_reg_o,
    output logic [$clog2(NUM_PHYS_REG)-1:0] commit_freed_reg_o,
    output logic                            commit_store_v_o,
    output logic                            mispredict_o,
    output logic [WORD_SIZE_P-1:0]          redirect_pc_o
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_commit_cnt_o,
    output logic [15:0]                     perf_mispredict_cnt_o
`endif
);

    localparam int IW = $clog2(ROB_ENTRY);
    localparam int AW = $clog2(NUM_ARCH_REG);
    localparam int PW = $clog2(NUM_PHYS_REG);
    localparam logic [IW:0] FULL_CNT = (IW+1)'(ROB_ENTRY);

    logic [ROB_ENTRY-1:0]   valid_q;
    logic [ROB_ENTRY-1:0]   wb_q;
    logic [ROB_ENTRY-1:0]   misp_q;
    logic [ROB_ENTRY-1:0]   spec_q;
    logic [ROB_ENTRY-1:0]   store_q;
    logic [ROB_ENTRY-1:0]   wv_q;
    logic [AW-1:0]          areg_q [ROB_ENTRY];
    logic [PW-1:0]          freg_q [ROB_ENTRY];
    logic [WORD_SIZE_P-1:0] rpc_q  [ROB_ENTRY];

    logic [IW-1:0] head_q;
    logic [IW-1:0] tail_q;
    logic [IW:0]   count_q;

    logic commit_v;
    logic flush;
    logic alloc;
    logic wb_hit;

    assign rob_ready_o = (count_q != FULL_CNT);
    assign rob_num_o   = tail_q;

    assign commit_v = valid_q[head_q] & wb_q[head_q];
    assign flush    = commit_v & misp_q[head_q];
    assign alloc    = rename_rob_v_i & rob_ready_o & ~flush;
    assign wb_hit   = wb_v_i & valid_q[wb_rob_i];

    assign commit_v_o         = commit_v;
    assign commit_w_v_o       = commit_v & wv_q[head_q];
    assign commit_alloc_reg_o = commit_v ? areg_q[head_q] : '0;
    assign commit_freed_reg_o = commit_v ? freg_q[head_q] : '0;
    assign commit_store_v_o   = commit_v & store_q[head_q];
    assign mispredict_o       = flush;
    assign redirect_pc_o      = flush ? rpc_q[head_q] : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            wb_q    <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            wb_q    <= '0;
        end else begin
            if (wb_hit)
                wb_q[wb_rob_i] <= 1'b1;
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                wb_q[tail_q]    <= 1'b0;
                tail_q          <= tail_q + 1'b1;
            end
            if (commit_v) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            case ({alloc, commit_v})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The PC field shares the resolved-PC slot: it is only ever observed as a redirect target.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            spec_q[tail_q]  <= rename_is_spec_i;
            store_q[tail_q] <= rename_is_store_i;
            wv_q[tail_q]    <= rename_w_v_i;
            areg_q[tail_q]  <= rename_alloc_reg_i;
            freg_q[tail_q]  <= rename_freed_reg_i;
            misp_q[tail_q]  <= 1'b0;
            rpc_q[tail_q]   <= rename_pc_i;
        end
        if (wb_hit && spec_q[wb_rob_i]) begin
            misp_q[wb_rob_i] <= wb_mispredict_i;
            rpc_q[wb_rob_i]  <= wb_resolved_pc_i;
        end
    end

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_commit_cnt_o     <= '0;
            perf_mispredict_cnt_o <= '0;
        end else begin
            if (commit_v && perf_commit_cnt_o != '1)
                perf_commit_cnt_o <= perf_commit_cnt_o + 1'b1;
            if (flush && perf_mispredict_cnt_o != '1)
                perf_mispredict_cnt_o <= perf_mispredict_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed plus random stimulus against a queue-based ROB reference model.
module tb_rob_commit;

    localparam int RE = 16;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        rename_rob_v_i;
    logic [15:0] rename_pc_i;
    logic        rename_is_spec_i;
    logic        rename_is_store_i;
    logic        rename_w_v_i;
    logic [2:0]  rename_alloc_reg_i;
    logic [4:0]  rename_freed_reg_i;
    logic        rob_ready_o;
    logic [3:0]  rob_num_o;
    logic        wb_v_i;
    logic [3:0]  wb_rob_i;
    logic        wb_mispredict_i;
    logic [15:0] wb_resolved_pc_i;
    logic        commit_v_o;
    logic        commit_w_v_o;
    logic [2:0]  commit_alloc_reg_o;
    logic [4:0]  commit_freed_reg_o;
    logic        commit_store_v_o;
    logic        mispredict_o;
    logic [15:0] redirect_pc_o;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit_cnt_o;
    logic [15:0] perf_mispredict_cnt_o;
`endif

    rob_commit #(
        .ROB_ENTRY   (16),
        .NUM_ARCH_REG(8),
        .NUM_PHYS_REG(32),
        .WORD_SIZE_P (16)
    ) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .rename_rob_v_i    (rename_rob_v_i),
        .rename_pc_i       (rename_pc_i),
        .rename_is_spec_i  (rename_is_spec_i),
        .rename_is_store_i (rename_is_store_i),
        .rename_w_v_i      (rename_w_v_i),
        .rename_alloc_reg_i(rename_alloc_reg_i),
        .rename_freed_reg_i(rename_freed_reg_i),
        .rob_ready_o       (rob_ready_o),
        .rob_num_o         (rob_num_o),
        .wb_v_i            (wb_v_i),
        .wb_rob_i          (wb_rob_i),
        .wb_mispredict_i   (wb_mispredict_i),
        .wb_resolved_pc_i  (wb_resolved_pc_i),
        .commit_v_o        (commit_v_o),
        .commit_w_v_o      (commit_w_v_o),
        .commit_alloc_reg_o(commit_alloc_reg_o),
        .commit_freed_reg_o(commit_freed_reg_o),
        .commit_store_v_o  (commit_store_v_o),
        .mispredict_o      (mispredict_o),
        .redirect_pc_o     (redirect_pc_o)
`ifdef ROB_PERF_CNT_EN
        ,
        .perf_commit_cnt_o    (perf_commit_cnt_o),
        .perf_mispredict_cnt_o(perf_mispredict_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned idx;
        bit          wb;
        bit          misp;
        bit          spec;
        bit          store;
        bit          wv;
        int unsigned areg;
        int unsigned freg;
        int unsigned rpc;
    } ent_t;

    ent_t        q[$];
    int unsigned m_tail;
    int unsigned m_commits;
    int unsigned m_misps;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        rename_rob_v_i     = 1'b0;
        rename_pc_i        = '0;
        rename_is_spec_i   = 1'b0;
        rename_is_store_i  = 1'b0;
        rename_w_v_i       = 1'b0;
        rename_alloc_reg_i = '0;
        rename_freed_reg_i = '0;
        wb_v_i             = 1'b0;
        wb_rob_i           = '0;
        wb_mispredict_i    = 1'b0;
        wb_resolved_pc_i   = '0;
    endtask

    // Compare outputs with the model, then advance the model and the DUT one clock.
    task automatic cycle();
        bit   e_ready;
        bit   e_cv;
        bit   e_mp;
        ent_t h;
        ent_t n;
        e_ready = (q.size() != RE);
        e_cv    = (q.size() > 0) && q[0].wb;
        e_mp    = e_cv && q[0].misp;
        if (q.size() > 0) h = q[0];
        check("rob_ready", 32'(rob_ready_o), 32'(e_ready));
        check("rob_num", 32'(rob_num_o), m_tail);
        check("commit_v", 32'(commit_v_o), 32'(e_cv));
        check("commit_w_v", 32'(commit_w_v_o), e_cv ? 32'(h.wv) : 0);
        check("commit_alloc", 32'(commit_alloc_reg_o), e_cv ? h.areg : 0);
        check("commit_freed", 32'(commit_freed_reg_o), e_cv ? h.freg : 0);
        check("commit_store", 32'(commit_store_v_o), e_cv ? 32'(h.store) : 0);
        check("mispredict", 32'(mispredict_o), 32'(e_mp));
        check("redirect_pc", 32'(redirect_pc_o), e_mp ? h.rpc : 0);
`ifdef ROB_PERF_CNT_EN
        check("perf_commit", perf_commit_cnt_o, m_commits);
        check("perf_misp", 32'(perf_mispredict_cnt_o), m_misps);
`endif
        if (e_cv) m_commits++;
        if (e_mp) m_misps++;
        if (wb_v_i) begin
            foreach (q[i]) begin
                if (q[i].idx == int'(wb_rob_i)) begin
                    q[i].wb = 1'b1;
                    if (q[i].spec) begin
                        q[i].misp = wb_mispredict_i;
                        q[i].rpc  = wb_resolved_pc_i;
                    end
                end
            end
        end
        if (e_mp) begin
            q.delete();
            m_tail = 0;
        end else begin
            if (e_cv) void'(q.pop_front());
            if (rename_rob_v_i && e_ready) begin
                n.idx = m_tail; n.wb = 1'b0; n.misp = 1'b0;
                n.spec = rename_is_spec_i; n.store = rename_is_store_i; n.wv = rename_w_v_i;
                n.areg = rename_alloc_reg_i; n.freg = rename_freed_reg_i; n.rpc = rename_pc_i;
                q.push_back(n);
                m_tail = (m_tail + 1) % RE;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset_n_i = 1'b0;
        q.delete();
        m_tail = 0; m_commits = 0; m_misps = 0;
        #1;
        check("rst_ready", 32'(rob_ready_o), 1);
        check("rst_rob_num", 32'(rob_num_o), 0);
        check("rst_commit_v", 32'(commit_v_o), 0);
        check("rst_mispredict", 32'(mispredict_o), 0);
        check("rst_redirect", 32'(redirect_pc_o), 0);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic alloc(input bit spec, input bit store, input bit wv,
                         input int unsigned areg, input int unsigned freg, input int unsigned pcv);
        rename_rob_v_i     = 1'b1;
        rename_is_spec_i   = spec;
        rename_is_store_i  = store;
        rename_w_v_i       = wv;
        rename_alloc_reg_i = 3'(areg);
        rename_freed_reg_i = 5'(freg);
        rename_pc_i        = 16'(pcv);
        cycle();
        idle();
    endtask

    task automatic wback(input int unsigned idx, input bit misp, input int unsigned rpc);
        wb_v_i           = 1'b1;
        wb_rob_i         = 4'(idx);
        wb_mispredict_i  = misp;
        wb_resolved_pc_i = 16'(rpc);
        cycle();
        idle();
    endtask

    task automatic drain();
        int unsigned pend;
        bit          found;
        for (int k = 0; k < 80; k++) begin
            if (q.size() == 0) break;
            found = 1'b0;
            foreach (q[i]) if (!found && !q[i].wb) begin found = 1'b1; pend = q[i].idx; end
            if (found) wback(pend, 1'b0, 0);
            else cycle();
        end
        check("drain_budget", q.size(), 0);
    endtask

    initial begin
        int unsigned prev_num;
        int          extra;
        n_checks = 0; n_fail = 0;
        m_tail = 0; m_commits = 0; m_misps = 0;
        idle();
        #12;
        check("init_ready", 32'(rob_ready_o), 1);
        check("init_rob_num", 32'(rob_num_o), 0);
        check("init_commit_v", 32'(commit_v_o), 0);
        check("init_redirect", 32'(redirect_pc_o), 0);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // In-order commit despite out-of-order writeback
        alloc(0, 0, 1, 2, 9, 16'h100);
        alloc(0, 0, 1, 3, 10, 16'h104);
        alloc(0, 0, 1, 4, 11, 16'h108);
        wback(2, 0, 0);
        wback(0, 0, 0);
        wback(1, 0, 0);
        for (int k = 0; k < 4; k++) cycle();
        check("inorder_empty", q.size(), 0);

        // Reset with live entries; stale writebacks afterwards must be ignored
        for (int k = 0; k < 5; k++) alloc(0, k % 2, 1, k, k + 3, 16'h200 + k);
        wback(4, 0, 0);
        do_reset();
        wback(1, 0, 0);
        cycle();
        check("post_rst_commit_v", 32'(commit_v_o), 0);

        // Fill to full, then one commit reopens the ROB
        for (int k = 0; k < RE; k++) alloc(0, 0, 1, k % 8, k, 16'h300 + k);
        check("full_ready", 32'(rob_ready_o), 0);
        check("full_rob_num", 32'(rob_num_o), 0);
        alloc(0, 0, 1, 7, 31, 16'h3ff);
        wback(0, 0, 0);
        cycle();
        check("reopen_ready", 32'(rob_ready_o), 1);
        check("reopen_rob_num", 32'(rob_num_o), 0);
        drain();

        // Simultaneous allocate and commit at count 7
        do_reset();
        for (int k = 0; k < 7; k++) alloc(0, 0, 1, k, k, 16'h400 + k);
        wback(0, 0, 0);
        prev_num = rob_num_o;
        check("same_cycle_commit_v", 32'(commit_v_o), 1);
        alloc(0, 1, 0, 5, 5, 16'h4ff);
        check("same_cycle_tail", 32'(rob_num_o), (prev_num + 1) % RE);
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            if (!rob_ready_o) break;
            alloc(0, 0, 1, 1, 1, 16'h500);
            extra++;
        end
        check("count_held_at_7", 32'(extra), 9);
        drain();

        // Mispredicting branch at entry 1 flushes the younger entries
        do_reset();
        alloc(0, 0, 1, 1, 20, 16'h600);
        alloc(1, 0, 0, 0, 0, 16'h604);
        alloc(0, 1, 0, 0, 0, 16'h608);
        alloc(0, 0, 1, 2, 21, 16'h60c);
        wback(1, 1, 16'h0040);
        wback(0, 0, 0);
        cycle();
        check("mp_flag", 32'(mispredict_o), 1);
        check("mp_commit_v", 32'(commit_v_o), 1);
        check("mp_redirect", 32'(redirect_pc_o), 32'h0040);
        alloc(0, 0, 1, 6, 6, 16'h700);
        check("flush_rob_num", 32'(rob_num_o), 0);
        check("flush_ready", 32'(rob_ready_o), 1);
        wback(2, 0, 0);
        check("flush_commit_v", 32'(commit_v_o), 0);

        // Mispredict flag on a non-speculative entry is ignored
        alloc(0, 0, 1, 3, 13, 16'h800);
        wback(0, 1, 16'h0999);
        check("nonspec_commit_v", 32'(commit_v_o), 1);
        check("nonspec_mispredict", 32'(mispredict_o), 0);
        cycle();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            rename_rob_v_i     = ($urandom_range(99) < 60);
            rename_is_spec_i   = ($urandom_range(9) < 2);
            rename_is_store_i  = $urandom_range(1);
            rename_w_v_i       = $urandom_range(1);
            rename_alloc_reg_i = 3'($urandom_range(7));
            rename_freed_reg_i = 5'($urandom_range(31));
            rename_pc_i        = 16'($urandom);
            wb_v_i             = ($urandom_range(99) < 50);
            if (q.size() > 0 && $urandom_range(9) < 8)
                wb_rob_i = 4'(q[$urandom_range(q.size() - 1)].idx);
            else
                wb_rob_i = 4'($urandom_range(15));
            wb_mispredict_i  = ($urandom_range(9) < 3);
            wb_resolved_pc_i = 16'($urandom);
            cycle();
        end
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer and in-order commit unit: the far end of the rename→ROB and commit→rename interfaces.
- Accepts one renamed entry per cycle from the rename stage and supplies the ROB index that entry receives.
- Marks entries complete on execute writeback.
- Retires the head entry in order, returning w_v/alloc_reg/freed_reg to rename, and signals mispredict so rename rolls back and the ROB flushes.

Parameters:
ROB_ENTRY, 16, number of entries (power of two, ≥4)
NUM_ARCH_REG, 8, architectural registers
NUM_PHYS_REG, 32, physical registers
WORD_SIZE_P, 16, PC/data word width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
rename_rob_v_i  in  1  allocate request from rename
rename_pc_i  in  WORD_SIZE_P  instruction PC
rename_is_spec_i  in  1  branch whose outcome may mispredict
rename_is_store_i  in  1  store instruction
rename_w_v_i  in  1  writes a register
rename_alloc_reg_i  in  $clog2(NUM_ARCH_REG)  architectural destination
rename_freed_reg_i  in  $clog2(NUM_PHYS_REG)  previous physical mapping of destination
rob_ready_o  out  1  ROB can accept an entry this cycle
rob_num_o  out  $clog2(ROB_ENTRY)  index the next allocation receives (tail)
wb_v_i  in  1  execute writeback valid
wb_rob_i  in  $clog2(ROB_ENTRY)  completing entry
wb_mispredict_i  in  1  completing branch mispredicted
wb_resolved_pc_i  in  WORD_SIZE_P  correct target for a mispredict
commit_v_o  out  1  head entry retires this cycle
commit_w_v_o  out  1  retiring entry wrote a register
commit_alloc_reg_o  out  $clog2(NUM_ARCH_REG)  retiring architectural destination
commit_freed_reg_o  out  $clog2(NUM_PHYS_REG)  physical register to free
commit_store_v_o  out  1  retiring entry is a store (store-buffer drain)
mispredict_o  out  1  retiring entry mispredicted; qualifies commit_v_o
redirect_pc_o  out  WORD_SIZE_P  fetch redirect target, valid with mispredict_o

Behaviour:
- Storage: circular array; per entry: valid, wb, mispredict, is_spec, is_store, w_v, alloc_reg, freed_reg, pc, resolved_pc.
- State: head and tail pointers, $clog2(ROB_ENTRY) bits, wrap modulo ROB_ENTRY. Count is $clog2(ROB_ENTRY)+1 bits.
- Reset (async, reset_n_i=0): head=tail=count=0, all valid/wb cleared. Outputs: rob_ready_o=1, rob_num_o=0, all commit_*, mispredict_o and redirect_pc_o = 0.
- rob_ready_o = (count != ROB_ENTRY), from registered count. A commit in the same cycle does not raise ready.
- Allocation: when rename_rob_v_i & rob_ready_o, write the entry at tail with valid=1, wb=0, mispredict=0. Tail increments next edge. rob_num_o = tail (combinational from the register).
- Writeback: wb_v_i sets wb at wb_rob_i; mispredict and resolved_pc are latched only if the entry's is_spec is set. Writeback to an invalid entry is ignored.
- Commit: commit_v_o = valid[head] & wb[head], combinational from registered state. At most one commit per cycle. There is no writeback bypass: a head written back in cycle N commits in N+1 at the earliest.
- commit_w_v_o, commit_alloc_reg_o, commit_freed_reg_o and commit_store_v_o mirror the head entry when commit_v_o=1, else 0.
- On commit: valid[head] cleared, head increments.
- Count: alloc-only +1, commit-only −1, both unchanged.
- Mispredict: mispredict_o = commit_v_o & mispredict[head]; redirect_pc_o = resolved_pc[head]. On that edge the whole ROB flushes: all valid cleared, head=tail=count=0. Any allocation in the same cycle is discarded; rename holds ready low then.
- Empty: commit_v_o=0 and writebacks are ignored.
- Full: allocation is blocked; writeback and commit proceed normally.

Optional Feature:
ROB_PERF_CNT_EN:
- Defined: adds outputs perf_commit_cnt_o (32b, +1 per commit_v_o) and perf_mispredict_cnt_o (16b, +1 per mispredict_o). Both saturate at all-ones, reset to 0, and are unaffected by flush.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset mid-run with 5 entries live → next cycle rob_ready_o=1, rob_num_o=0, commit_v_o=0; old writebacks ignored.
- Allocate 3 (w_v=1, alloc 2/3/4, freed 9/10/11); writeback order 2,0,1 → commits in order 0,1,2 on consecutive cycles, freed 9,10,11, each one cycle after its wb is visible.
- Fill 16 entries → rob_ready_o=0 at count 16; commit one → ready=1 the following cycle, rob_num_o=0 after wrap.
- Allocate and commit in the same cycle at count 7 → count stays 7, tail and head both advance.
- Branch entry 1 of 4 written back with wb_mispredict_i=1, resolved_pc=0x0040 → commit entry 0, then commit_v_o=mispredict_o=1 with redirect 0x0040; next cycle count=0, entries 2-3 gone, a concurrent allocate is dropped.
- Writeback to a non-spec entry with wb_mispredict_i=1 → commits without mispredict_o.
